// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: pad synchroniser, per-bit tick-based debouncer
// and registered one-cycle rise/fall/changed pulses.
module gpio_in_debounce #(
    parameter int WIDTH        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [PW-1:0]                     pcnt_q, pcnt_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  gpio_q, gpio_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;
    logic [WIDTH-1:0]                  s;
    logic                              tick_w;

    assign s       = sync_q[SYNC_STAGES-1];
    assign tick_w  = (pcnt_q == PLAST);
    assign gpio_in = gpio_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

    always_comb begin
        sync_d[0] = raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign pcnt_d = tick_w ? '0 : pcnt_q + 1'b1;

    // Any agreement with the accepted level restarts the count.
    always_comb begin
        gpio_d = gpio_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == gpio_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_w) begin
                if (cnt_q[i] == CLAST) begin
                    gpio_d[i] = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            pcnt_q    <= '0;
            cnt_q     <= '0;
            gpio_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            gpio_q    <= gpio_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with PRESCALE=4, STABLE_TICKS=3,
// plus a PRESCALE=1 instance for the every-cycle tick case.
module tb_gpio_in_debounce;

    logic        clock;
    logic        reset;
    logic [15:0] raw_in;
    logic [15:0] gpio_in, rise, fall;
    logic        changed;
    logic [15:0] p1_gpio, p1_rise, p1_fall;
    logic        p1_changed;

    int checks = 0;
    int passes = 0;
    int n;

    gpio_in_debounce #(
        .WIDTH(16), .SYNC_STAGES(2), .PRESCALE(4), .STABLE_TICKS(3)
    ) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .gpio_in(gpio_in), .rise(rise), .fall(fall), .changed(changed)
    );

    gpio_in_debounce #(
        .WIDTH(16), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(3)
    ) dut_p1 (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .gpio_in(p1_gpio), .rise(p1_rise), .fall(p1_fall),
        .changed(p1_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 16'hFFFF;
        // 1: outputs stay clear throughout reset
        for (int j = 0; j < 3; j++) begin
            step(1);
            check("rst_gpio", 32'(gpio_in), 32'h0);
            check("rst_pulse", {15'h0, changed, rise | fall}, 32'h0);
        end
        reset = 1'b0;
        // 1 + 6: accepted at edge 12, ticks on cycles 3,7,11,...
        for (int k = 0; k < 20; k++) begin
            check("tick", 32'(dut.tick_w), 32'((k % 4) == 3));
            check("tick_p1", 32'(dut_p1.tick_w), 32'h1);
            check("t1_gpio", 32'(gpio_in), (k >= 12) ? 32'hFFFF : 32'h0);
            check("t1_rise", 32'(rise), (k == 12) ? 32'hFFFF : 32'h0);
            check("t1_fall", 32'(fall), 32'h0);
            check("t1_chg", 32'(changed), 32'(k == 12));
            check("p1_gpio", 32'(p1_gpio), (k >= 5) ? 32'hFFFF : 32'h0);
            check("p1_rise", 32'(p1_rise), (k == 5) ? 32'hFFFF : 32'h0);
            check("p1_fall", 32'(p1_fall), 32'h0);
            check("p1_chg", 32'(p1_changed), 32'(k == 5));
            step(1);
        end

        // Return all bits low
        raw_in = 16'h0000;
        n = 0;
        while (gpio_in != 16'h0000 && n < 40) begin
            step(1);
            n++;
        end
        check("fall_all_gpio", 32'(gpio_in), 32'h0);
        check("fall_all", 32'(fall), 32'hFFFF);
        step(1);
        check("fall_all_end", 32'(fall), 32'h0);

        // 2: single-bit step, latency 11..14
        raw_in = 16'h0001;
        n = 0;
        do begin
            step(1);
            n++;
        end while (gpio_in[0] == 1'b0 && n < 20);
        check("t2_latency", 32'(n >= 11 && n <= 14), 32'h1);
        check("t2_gpio", 32'(gpio_in), 32'h0001);
        check("t2_rise", 32'(rise), 32'h0001);
        check("t2_fall", 32'(fall), 32'h0);
        check("t2_chg", 32'(changed), 32'h1);
        step(1);
        check("t2_rise_end", 32'(rise), 32'h0);
        check("t2_chg_end", 32'(changed), 32'h0);

        // 3: six-cycle glitch on bit 3 is rejected
        raw_in = 16'h0009;
        for (int j = 0; j < 6; j++) begin
            step(1);
            check("t3_gpio", 32'(gpio_in), 32'h0001);
            check("t3_chg", 32'(changed), 32'h0);
        end
        raw_in = 16'h0001;
        step(2);
        check("t3_counting", 32'(dut.cnt_q[3] != 0), 32'h1);
        step(1);
        check("t3_cnt_clr", 32'(dut.cnt_q[3]), 32'h0);
        for (int j = 0; j < 12; j++) begin
            step(1);
            check("t3_gpio_after", 32'(gpio_in), 32'h0001);
            check("t3_pulses", {15'h0, changed, rise | fall}, 32'h0);
        end

        // 4: simultaneous rise on bit 15 and fall on bit 0
        raw_in = 16'h8000;
        n = 0;
        while (gpio_in == 16'h0001 && n < 20) begin
            step(1);
            n++;
        end
        check("t4_gpio", 32'(gpio_in), 32'h8000);
        check("t4_rise", 32'(rise), 32'h8000);
        check("t4_fall", 32'(fall), 32'h0001);
        check("t4_chg", 32'(changed), 32'h1);
        step(1);
        check("t4_gpio_hold", 32'(gpio_in), 32'h8000);
        check("t4_pulses_end", {15'h0, changed, rise | fall}, 32'h0);

        // 5: reset after two ticks of counting discards the progress
        raw_in = 16'h8020;
        n = 0;
        while (dut.cnt_q[5] != 2 && n < 20) begin
            step(1);
            n++;
        end
        check("t5_cnt2", 32'(dut.cnt_q[5]), 32'h2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_gpio_rst", 32'(gpio_in), 32'h0);
        check("t5_cnt_rst", 32'(dut.cnt_q[5]), 32'h0);
        n = 0;
        do begin
            step(1);
            n++;
        end while (gpio_in[5] == 1'b0 && n < 30);
        check("t5_latency", 32'(n), 32'd12);
        check("t5_gpio", 32'(gpio_in), 32'h8020);
        check("t5_rise", 32'(rise), 32'h8020);
        check("t5_chg", 32'(changed), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
